// File: rtl/scale_mux_arbiter.sv
// rtl/scale_mux_arbiter.sv - round-robin two-requester arbiter sharing one scale_mux
// into a one-entry registered output with valid/ready on both sides.

module scale_mux #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             sel_a,
   output logic [WIDTH-1:0] mux_out
);
   assign mux_out = sel_a ? in_a : in_b;
endmodule

module scale_mux_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic [7:0]       grant_cnt_a,
   output logic [7:0]       grant_cnt_b
);
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_src_q, out_src_d;
   logic             last_grant_a_q, last_grant_a_d;
   logic [7:0]       cnt_a_q, cnt_a_d;
   logic [7:0]       cnt_b_q, cnt_b_d;

   logic             load;
   logic             grant_a;
   logic             grant_b;
   logic             accept;
   logic [WIDTH-1:0] mux_data;

   scale_mux #(.WIDTH(WIDTH)) u_mux (
      .in_a    (a_data),
      .in_b    (b_data),
      .sel_a   (grant_a),
      .mux_out (mux_data)
   );

   // On a tie the requester that did not win last time gets the slot.
   always_comb begin
      grant_a = a_valid && (!b_valid || !last_grant_a_q);
      grant_b = b_valid && (!a_valid || last_grant_a_q);
      load    = !out_valid_q || out_ready;
      a_ready = !rst && load && grant_a;
      b_ready = !rst && load && grant_b;
      accept  = (a_valid && a_ready) || (b_valid && b_ready);
   end

   always_comb begin
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_src_d      = out_src_q;
      last_grant_a_d = last_grant_a_q;
      cnt_a_d        = cnt_a_q;
      cnt_b_d        = cnt_b_q;
      if (accept) begin
         out_valid_d    = 1'b1;
         out_data_d     = mux_data;
         out_src_d      = grant_a;
         last_grant_a_d = grant_a;
         if (grant_a && cnt_a_q != 8'hFF) cnt_a_d = cnt_a_q + 8'd1;
         if (grant_b && cnt_b_q != 8'hFF) cnt_b_d = cnt_b_q + 8'd1;
      end else if (out_ready && out_valid_q) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_src_q      <= 1'b0;
         last_grant_a_q <= 1'b0;
         cnt_a_q        <= 8'd0;
         cnt_b_q        <= 8'd0;
      end else begin
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_src_q      <= out_src_d;
         last_grant_a_q <= last_grant_a_d;
         cnt_a_q        <= cnt_a_d;
         cnt_b_q        <= cnt_b_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_src     = out_src_q;
   assign grant_cnt_a = cnt_a_q;
   assign grant_cnt_b = cnt_b_q;
endmodule

// File: tb/tb_scale_mux_arbiter.sv
// tb/tb_scale_mux_arbiter.sv - directed vector bench for scale_mux_arbiter.

module tb_scale_mux_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid, out_ready;
   logic [7:0] a_data, b_data;
   logic       a_ready, b_ready, out_valid, out_src;
   logic [7:0] out_data, grant_cnt_a, grant_cnt_b;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   scale_mux_arbiter #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .a_valid     (a_valid),
      .a_data      (a_data),
      .a_ready     (a_ready),
      .b_valid     (b_valid),
      .b_data      (b_data),
      .b_ready     (b_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_src     (out_src),
      .out_ready   (out_ready),
      .grant_cnt_a (grant_cnt_a),
      .grant_cnt_b (grant_cnt_b)
   );

   typedef struct {
      logic       rst;
      logic       av;
      logic [7:0] ad;
      logic       bv;
      logic [7:0] bd;
      logic       ordy;
      logic       e_ar;
      logic       e_br;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_src;
      logic [7:0] e_ca;
      logic [7:0] e_cb;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input logic r, input logic av, input logic [7:0] ad,
                      input logic bv, input logic [7:0] bd, input logic ordy,
                      input logic ear, input logic ebr, input logic eov,
                      input logic [7:0] eod, input logic esrc,
                      input logic [7:0] eca, input logic [7:0] ecb);
      vec_t v;
      v.rst = r; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
      v.e_ar = ear; v.e_br = ebr; v.e_ov = eov; v.e_od = eod; v.e_src = esrc;
      v.e_ca = eca; v.e_cb = ecb;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic av, input logic [7:0] ad,
                        input logic bv, input logic [7:0] bd, input logic ordy);
      rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst = 0;
   endtask

   int         exp_word;
   int         delivered;
   logic       m_ov;
   logic [7:0] m_od;
   logic [7:0] next_a;
   logic       m_load;

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      //   rst av ad     bv bd     ordy ar br ov od     src ca    cb
      add(1, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 8'd0, 8'd0);
      add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h00, 0, 8'd0, 8'd0);
      add(0, 1, 8'h3C, 0, 8'h00, 1,   1, 0, 1, 8'h3C, 1, 8'd1, 8'd0);
      add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h3C, 1, 8'd1, 8'd0);
      add(1, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h00, 0, 8'd0, 8'd0);
      add(0, 1, 8'hA0, 1, 8'hB0, 1,   1, 0, 1, 8'hA0, 1, 8'd1, 8'd0);
      add(0, 1, 8'hA1, 1, 8'hB0, 1,   0, 1, 1, 8'hB0, 0, 8'd1, 8'd1);
      add(0, 1, 8'hA1, 1, 8'hB1, 1,   1, 0, 1, 8'hA1, 1, 8'd2, 8'd1);
      add(0, 1, 8'hA2, 1, 8'hB1, 1,   0, 1, 1, 8'hB1, 0, 8'd2, 8'd2);
      add(0, 1, 8'hA2, 1, 8'hB2, 1,   1, 0, 1, 8'hA2, 1, 8'd3, 8'd2);
      add(0, 1, 8'hA3, 1, 8'hB2, 1,   0, 1, 1, 8'hB2, 0, 8'd3, 8'd3);
      add(0, 1, 8'hA3, 1, 8'hB3, 1,   1, 0, 1, 8'hA3, 1, 8'd4, 8'd3);
      for (int i = 0; i < 4; i++)
         add(0, 1, 8'hA4, 1, 8'hB3, 0, 0, 0, 1, 8'hA3, 1, 8'd4, 8'd3);
      add(0, 1, 8'hA4, 1, 8'hB3, 1,   0, 1, 1, 8'hB3, 0, 8'd4, 8'd4);
      add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'hB3, 0, 8'd4, 8'd4);
      add(0, 1, 8'h55, 0, 8'h00, 0,   1, 0, 1, 8'h55, 1, 8'd5, 8'd4);
      add(1, 1, 8'h66, 1, 8'h77, 0,   0, 0, 0, 8'h00, 0, 8'd0, 8'd0);
      add(0, 1, 8'h11, 1, 8'h22, 1,   1, 0, 1, 8'h11, 1, 8'd1, 8'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
         #1;
         check($sformatf("v%0d a_ready", i), a_ready, vecs[i].e_ar);
         check($sformatf("v%0d b_ready", i), b_ready, vecs[i].e_br);
         @(posedge clk); #1;
         check($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_ov);
         check($sformatf("v%0d out_data", i), out_data, vecs[i].e_od);
         check($sformatf("v%0d out_src", i), out_src, vecs[i].e_src);
         check($sformatf("v%0d cnt_a", i), grant_cnt_a, vecs[i].e_ca);
         check($sformatf("v%0d cnt_b", i), grant_cnt_b, vecs[i].e_cb);
      end

      // B alone for 300 cycles: every word lands, counter pins at 255.
      do_reset();
      delivered = 0;
      for (int i = 0; i < 300; i++) begin
         drive(0, 0, 0, 1, 8'(i), 1);
         #1;
         check("sat b_ready", b_ready, 1'b1);
         @(posedge clk); #1;
         if (out_valid && !out_src && out_data == 8'(i)) delivered++;
      end
      drive(0, 0, 0, 0, 0, 1);
      check("sat delivered", delivered, 300);
      check("sat cnt_b", grant_cnt_b, 8'd255);
      check("sat cnt_a", grant_cnt_a, 8'd0);
      @(posedge clk); #1;
      check("sat drained", out_valid, 1'b0);

      // A continuously valid with out_ready toggling; model load and scoreboard delivery.
      do_reset();
      m_ov = 0; m_od = 0; next_a = 8'h40; exp_word = 8'h40;
      for (int i = 0; i < 12; i++) begin
         drive(0, 1, next_a, 0, 0, (i % 2 == 0));
         #1;
         m_load = !m_ov || out_ready;
         check("alt a_ready", a_ready, m_load);
         if (out_valid && out_ready) begin
            check("alt delivered word", out_data, 8'(exp_word));
            exp_word++;
         end
         @(posedge clk); #1;
         if (m_load) begin
            m_ov = 1; m_od = next_a; next_a++;
         end
         check("alt out_valid", out_valid, m_ov);
         check("alt out_data", out_data, m_od);
      end
      check("alt cnt_a", grant_cnt_a, 8'(next_a - 8'h40));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/scale_mux_arbiter.md
# scale_mux_arbiter

Round-robin two-requester arbiter that shares a single `scale_mux` datapath between channel A and channel B. Each requester offers a WIDTH-bit word over a valid/ready handshake. The arbiter drives the mux select from its grant decision and captures the selected word into a one-entry output register. It presents that register downstream over a second valid/ready handshake, at full throughput of one word per cycle.

## Interface
- `WIDTH`, default 8: data width of both request channels and the output channel.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  synchronous, active-high reset.
- `a_valid`  input  1  requester A offers `a_data`.
- `a_data`  input  WIDTH  requester A word.
- `a_ready`  output  1  A's word is accepted this cycle.
- `b_valid`  input  1  requester B offers `b_data`.
- `b_data`  input  WIDTH  requester B word.
- `b_ready`  output  1  B's word is accepted this cycle.
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  WIDTH  registered word.
- `out_src`  output  1  source of `out_data`: 1 = A, 0 = B.
- `out_ready`  input  1  downstream accepts `out_data` this cycle.
- `grant_cnt_a`, `grant_cnt_b`  output  8 each  saturating count of accepted words per requester.

## Operation
- Internal `scale_mux #(WIDTH)` instance: `in_a = a_data`, `in_b = b_data`, `sel_a = grant_a`. Select polarity: `sel_a` = 1 passes A.
- `load = !out_valid || out_ready`. The output register can take a new word this cycle.
- Grant, combinational:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not `last_grant`.
  - Neither valid: no grant, and `grant_a` = 0.
- `a_ready = load && grant_a`; `b_ready = load && grant_b`. Ready may depend on valid; a requester's valid must not depend on its ready.
- Requester rules: once a requester raises valid, it holds valid and data stable until ready. The arbiter tolerates violations without corrupting state.
- On an accepted transfer (`a_valid && a_ready` or `b_valid && b_ready`):
  - `out_data` takes the mux output.
  - `out_src` takes `grant_a`.
  - `out_valid` is set to 1.
  - `last_grant` takes the granted requester.
  - The granted `grant_cnt` increments, saturating at 255.
- `out_ready && out_valid` with no new accept: `out_valid` is cleared to 0; `out_data` and `out_src` hold their values.
- `last_grant` changes only on an accepted transfer. A grant that stalls because `load` = 0 does not rotate priority.
- State is `out_valid`, `out_data`, `out_src`, `last_grant`, and the two counters. No other FSM is needed. The two effective states are EMPTY and FULL, selected by `out_valid`:
  - EMPTY → FULL on accept.
  - FULL → FULL on drain and accept in the same cycle.
  - FULL → EMPTY on drain with no accept.
  - FULL → FULL while stalled (`out_ready` = 0).

## Timing
- Reset values, applied on the clock edge where `rst` = 1:
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0.
  - `last_grant` = B, so A wins the first tie.
  - `grant_cnt_a` = `grant_cnt_b` = 0.
- Reset asserted mid-transfer: any word held in the output register is discarded.
- While `rst` = 1, `a_ready` and `b_ready` are forced to 0.
- Latency: a word accepted at edge N is visible on `out_data` with `out_valid` = 1 immediately after edge N, i.e. in cycle N+1.
- Throughput: with `out_ready` held at 1, one word is transferred per cycle.
- Under continuous contention, grants alternate strictly A, B, A, B.
- Backpressure: while `out_valid` = 1 and `out_ready` = 0:
  - `a_ready` = `b_ready` = 0.
  - `out_data` and `out_src` are stable.
- Simultaneous drain and accept in one cycle: the register is overwritten with no bubble cycle.
- Counter saturation: each `grant_cnt` holds at 255 and does not wrap.

## Test plan
- Reset, then idle: `out_valid` = 0, both readys = 0, both counters = 0. Then `a_valid` = 1, `a_data` = 8'h3C → `a_ready` = 1 in the same cycle; next cycle `out_data` = 8'h3C, `out_src` = 1.
- Both valid for 6 cycles with `out_ready` = 1, A offering 8'hA0..A5 and B offering 8'hB0..B5 → output sequence A0, B0, A1, B1, A2, B2; `grant_cnt_a` = `grant_cnt_b` = 3.
- Both valid, `out_ready` = 0 for 4 cycles after the first accept → `out_data` is held, no ready asserted, `last_grant` = A. When `out_ready` rises, the next word comes from B.
- Only B valid for 300 cycles with `out_ready` = 1 → 300 B words delivered; `grant_cnt_b` = 255 (saturated), `grant_cnt_a` = 0.
- `rst` asserted while `out_valid` = 1 holding 8'h55 → next cycle `out_valid` = 0, `out_data` = 0, counters = 0. The first tie after reset grants A.
- Alternating `out_ready` (1, 0, 1, 0) with A valid continuously → exactly one accept per cycle in which `load` = 1, and no duplicated or dropped words.
